// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned SUB_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

endpackage

// File: rtl/full_subtractor_1bit.sv
// Single-bit full subtractor cell: d = x - y - bin, bo = borrow out.
module full_subtractor_1bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  // Difference and borrow of one bit column
  always_comb begin
    d  = x ^ y ^ bin;
    bo = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial two's-complement subtractor, diff = a - b, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor_4bit
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_bo;
  logic             last_bit;
  logic             accept;

  full_subtractor_1bit u_cell (
    .x   (a_sr[0]),
    .y   (b_sr[0]),
    .bin (borrow),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  // Decode the final bit of an operation and whether this edge takes a new one
  always_comb begin
    last_bit = (cnt == CW'(WIDTH - 1));
    accept   = start && (state != SHIFT);
  end

  // Control FSM with registered busy/done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Operand/result shift registers, borrow and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf     <= 1'b0;
`endif
    end else if (accept) begin
      a_sr    <= a;
      b_sr    <= b;
      diff_sr <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf     <= 1'b0;
`endif
    end else if (state == SHIFT) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      diff_sr <= {cell_d, diff_sr[WIDTH-1:1]};
      borrow  <= cell_bo;
      // Hold the counter on the final bit so it never wraps
      if (!last_bit) begin
        cnt <= cnt + CW'(1);
      end
`ifdef SERIAL_SUB_OVERFLOW_EN
      // On the final bit the cell sees the operand sign bits
      if (last_bit) begin
        ovf <= (a_sr[0] != b_sr[0]) && (cell_d != a_sr[0]);
      end
`endif
    end
  end

  assign diff = diff_sr;
  assign bout = borrow;

endmodule
